// File: rtl/mux4_lock_pkg.sv
// Shared types and index helpers for the MUX4 key-lock controller.
package mux4_lock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ARMED = 3'd3,
    ERROR = 3'd4
  } lock_state_e;

  function automatic int key_w(input int num_locks);
    return 4 * num_locks;
  endfunction

  // Flat key bit feeding gate i for selector pair {b, a}.
  function automatic int gate_idx(input int i, input int b, input int a);
    return 4 * i + 2 * b + a;
  endfunction

endpackage

// File: rtl/mux4_keygate.sv
// Single 4:1 key-gate: the locked core's selectors pick one of four key bits.
module mux4_keygate (
  input  logic [3:0] key,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       en,
  output logic       y
);

  assign y = en & key[{sel_b, sel_a}];

endmodule

// File: rtl/mux4_key_lock_ctrl.sv
// Serial key loader with even-parity check driving NUM_LOCKS MUX4 key-gates.
module mux4_key_lock_ctrl
  import mux4_lock_pkg::*;
#(
  parameter int NUM_LOCKS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 zeroize,
  input  logic                 key_in_valid,
  input  logic                 key_in_bit,
  output logic                 key_in_ready,
  input  logic [NUM_LOCKS-1:0] sel_a,
  input  logic [NUM_LOCKS-1:0] sel_b,
  output logic [NUM_LOCKS-1:0] lock_out,
  output logic                 armed,
  output logic                 key_error,
  output logic                 busy,
  output lock_state_e          state_dbg
);

  localparam int KEY_W = key_w(NUM_LOCKS);
  localparam int CNT_W = $clog2(KEY_W + 1);

  lock_state_e       state_q, state_d;
  logic [KEY_W-1:0]  shadow_q, active_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              par_q, ok_q;
  logic              transfer, last_bit, gate_en;

  // Handshake: a bit moves on a rising edge where key_in_valid && key_in_ready;
  // ready never depends on valid, and a held valid with ready low is simply ignored.
  assign transfer = key_in_valid && key_in_ready;
  assign last_bit = (cnt_q == CNT_W'(KEY_W));
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (transfer) state_d = LOAD;
        LOAD:    if (transfer && last_bit) state_d = CHECK;
        CHECK:   state_d = ok_q ? ARMED : ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    key_in_ready = 1'b0;
    armed        = 1'b0;
    key_error    = 1'b0;
    busy         = 1'b0;
    gate_en      = 1'b0;
    case (state_q)
      IDLE, LOAD: key_in_ready = !rst && !zeroize;
      default:    key_in_ready = 1'b0;
    endcase
    case (state_q)
      LOAD, CHECK: busy = 1'b1;
      ARMED: begin
        armed   = 1'b1;
        gate_en = 1'b1;
      end
      ERROR:   key_error = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (transfer) begin
          shadow_q <= {{(KEY_W-1){1'b0}}, key_in_bit};
          cnt_q    <= CNT_W'(1);
          par_q    <= key_in_bit;
        end
        LOAD: if (transfer) begin
          if (!last_bit) begin
            shadow_q <= shadow_q | (KEY_W'(key_in_bit) << cnt_q);
            par_q    <= par_q ^ key_in_bit;
            cnt_q    <= cnt_q + CNT_W'(1);
          end else begin
            // The final bit is parity: data bits plus it must have even weight.
            ok_q <= ~(par_q ^ key_in_bit);
          end
        end
        CHECK: begin
          if (ok_q) active_q <= shadow_q;
          else      shadow_q <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_gate
    mux4_keygate u_gate (
      .key   (active_q[gate_idx(i, 0, 0) +: 4]),
      .sel_a (sel_a[i]),
      .sel_b (sel_b[i]),
      .en    (gate_en),
      .y     (lock_out[i])
    );
  end

endmodule

// File: doc/mux4_key_lock_ctrl.md
Name: mux4_key_lock_ctrl

Overview:
- Sequential key-management and key-gate block for MUX4-locked netlists.
- Accepts the secret key bit-serially over a valid/ready handshake, checks even parity and holds the key in an active register.
- Drives NUM_LOCKS 4:1 key-gates: each gate's two locked-netlist selector nets pick one of its four key bits.
- Parametrised successor to hard-wired per-design key inputs. Sits between the chip key port and the locked combinational core.

Parameters:
- NUM_LOCKS, 5, number of MUX4 key-gates; legal range 1..64.
- KEY_W, 4*NUM_LOCKS, derived total key width; not overridable.
- CNT_W, $clog2(KEY_W+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- zeroize  input  1  synchronous key wipe; return to IDLE.
- key_in_valid  input  1  serial key bit present.
- key_in_bit  input  1  serial key data, key bit 0 first, parity bit last.
- key_in_ready  output  1  block accepts a bit this cycle.
- sel_a  input  NUM_LOCKS  per-gate selector LSB, from the locked core.
- sel_b  input  NUM_LOCKS  per-gate selector MSB, from the locked core.
- lock_out  output  NUM_LOCKS  key-gate outputs to the locked core.
- armed  output  1  a valid key is active.
- key_error  output  1  last load failed parity.
- busy  output  1  a load is in progress (LOAD or CHECK).

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; shadow key, active key, counter and parity accumulator all 0. armed=0, key_error=0, busy=0, lock_out=0. key_in_ready=0 while rst=1.
- Transfer: key_in_valid && key_in_ready on a rising edge. key_in_ready=1 only in IDLE or LOAD, with rst=0 and zeroize=0.
- IDLE, on transfer: shadow[0]=bit, cnt=1, par=bit; go to LOAD.
- LOAD, on transfer with cnt<KEY_W: shadow[cnt]=bit, par^=bit, cnt++.
- LOAD, on transfer with cnt==KEY_W: the bit is the parity bit. Register ok=(par^bit)==0 and go to CHECK.
- LOAD, with valid low: hold all state. No timeout.
- CHECK lasts exactly one cycle:
  - If ok: active key <= shadow; go to ARMED.
  - Else: shadow cleared; go to ERROR.
- ARMED: armed=1, key_in_ready=0. A new key can be loaded only after zeroize or rst.
- ERROR: key_error=1, key_in_ready=0, active key stays 0. Sticky until zeroize or rst.
- Latency: if the parity bit is accepted on edge E, armed (or key_error) becomes 1 after edge E+1.
- Key-gate (combinational):
  - In ARMED: lock_out[i] = active_key[4*i + {sel_b[i], sel_a[i]}].
  - Key bit order per gate: 4i = (b=0,a=0), 4i+1 = (b=0,a=1), 4i+2 = (b=1,a=0), 4i+3 = (b=1,a=1).
  - In any other state: lock_out = 0, whatever the selector values.
- zeroize, from any state: next state IDLE; both key registers, cnt and par cleared; armed and key_error drop after the edge.
- Priority: rst > zeroize > transfer. A transfer presented in the same cycle as zeroize is not accepted, because ready is forced low.
- The key is never readable through any port. No output depends on shadow contents before ARMED.
- Registered outputs: armed, key_error and busy are decoded from the state register. lock_out is combinational from the registers and selectors, with no added latency.

Decomposition:
- Package mux4_lock_pkg holds:
  - the state enum {IDLE, LOAD, CHECK, ARMED, ERROR};
  - function key_w(num_locks) = 4*num_locks;
  - function gate_idx(i, b, a) = 4*i + 2*b + a.
- Sub-module mux4_keygate is a purely combinational single gate: ports key[3:0], sel_a, sel_b, en, y; y=0 when en=0. It is instantiated NUM_LOCKS times via generate. The controller FSM stays in the top.

Test Plan (NUM_LOCKS=2, KEY_W=8):
- Good load: send key 8'hA5 LSB-first (bits 1,0,1,0,0,1,0,1), then parity bit 0, valid held high.
  - armed=1 one edge after the parity edge; busy=0.
  - With {b,a} selectors {00,01,10,11}: lock_out[0] gives 1,0,1,0 and lock_out[1] gives 0,1,0,1.
- Bad parity: send 8'hA5 with parity bit 1.
  - key_error=1, armed=0, lock_out=2'b00 for all selector values, key_in_ready=0.
  - Holds for 20 cycles.
- Stalls: send 8'hA5 with valid low for 3 cycles between each bit.
  - Same result as the good load; counter does not advance during gaps; busy=1 throughout.
- Mid-load zeroize: assert zeroize after 3 bits, together with valid=1.
  - That bit is not accepted; state returns to IDLE with busy=0.
  - A subsequent full load of 8'h3C with parity 0 arms with key 3C.
- Reset while ARMED: assert rst for 1 cycle after a good load.
  - armed=0, lock_out=0, key_error=0, key_in_ready=0 during rst and 1 after.
  - Reload of 8'hFF with parity 0 arms with lock_out=2'b11 for all selectors.
- ERROR recovery: zeroize in ERROR clears key_error the next cycle; a good 8'h01 load with parity 1 then arms.
